// File: rtl/nes_pad_emulator_if.sv
// Host-facing pad link plus debounced status taps of the NES pad emulator.
interface nes_pad_emulator_if;
  logic       latch_in;
  logic       pulse_in;
  logic [7:0] buttons_in;
  logic       data_out;
  logic [7:0] buttons_db;
  logic       busy;
  logic       frame_done;
  logic       timeout;

  modport master (
    output latch_in, pulse_in, buttons_in,
    input  data_out, buttons_db, busy, frame_done, timeout
  );

  modport slave (
    input  latch_in, pulse_in, buttons_in,
    output data_out, buttons_db, busy, frame_done, timeout
  );
endinterface

// File: rtl/nes_pad_emulator.sv
// 4021-style NES pad emulator: synchronizes host latch/pulse, debounces 8 buttons,
// snapshots them on latch and shifts them out active-low, one bit per host pulse.
module nes_pad_emulator #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   TIMEOUT_CYCLES  = 1000000,
  parameter logic TAIL_BIT        = 1'b1
) (
  input logic               clk,
  input logic               reset,
  nes_pad_emulator_if.slave pad
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_e;

  logic [SYNC_STAGES-1:0]      latch_sync_q, pulse_sync_q;
  logic [SYNC_STAGES-1:0][7:0] btn_sync_q;
  logic                        latch_d1_q, pulse_d1_q;
  logic                        latch_s, pulse_s, latch_rise, latch_fall, pulse_rise;
  logic [7:0]                  raw_s;

  logic [7:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [7:0]         buttons_db_q, buttons_db_d;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          data_out_q, data_out_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_q, timeout_d;

  // ---- synchronizers and edge detect ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      btn_sync_q   <= '0;
      latch_d1_q   <= 1'b0;
      pulse_d1_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.latch_in};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pad.pulse_in};
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], pad.buttons_in};
      latch_d1_q   <= latch_s;
      pulse_d1_q   <= pulse_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
  assign raw_s      = btn_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d1_q;
  assign latch_fall = ~latch_s & latch_d1_q;
  assign pulse_rise = pulse_s & ~pulse_d1_q;

  // ---- per-button debounce: count only while raw disagrees with accepted level ----
  always_comb begin
    db_cnt_d     = db_cnt_q;
    buttons_db_d = buttons_db_q;
    for (int i = 0; i < 8; i++) begin
      if (raw_s[i] == buttons_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]     = '0;
        buttons_db_d[i] = raw_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q     <= '0;
      buttons_db_q <= '0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      buttons_db_q <= buttons_db_d;
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= 8'hFF;
      bit_idx_q    <= '0;
      timer_q      <= '0;
      data_out_q   <= TAIL_BIT;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    unique case (state_q)
      IDLE, TAIL: begin
        if (latch_rise) state_d = LOAD;
      end
      LOAD: begin
        // Snapshot tracks buttons_db until latch falls, then is frozen for the frame.
        shift_d = ~buttons_db_q;
        if (latch_fall) begin
          state_d   = SHIFT;
          bit_idx_d = '0;
          timer_d   = '0;
        end
      end
      SHIFT: begin
        // A high latch here (even without a seen rise) restarts the frame; pulse dropped.
        if (latch_s) begin
          state_d = LOAD;
        end else if (pulse_rise) begin
          shift_d = {1'b1, shift_q[7:1]};
          timer_d = '0;
          if (bit_idx_q == 3'd7) state_d   = TAIL;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else if (timer_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    data_out_d   = (state_q == LOAD || state_q == SHIFT) ? shift_q[0] : TAIL_BIT;
    frame_done_d = (state_q == SHIFT) && !latch_s && pulse_rise && (bit_idx_q == 3'd7);
    timeout_d    = (state_q == SHIFT) && !latch_s && !pulse_rise && (timer_q == TO_LAST);
  end

  assign pad.data_out   = data_out_q;
  assign pad.buttons_db = buttons_db_q;
  assign pad.busy       = (state_q != IDLE);
  assign pad.frame_done = frame_done_q;
  assign pad.timeout    = timeout_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Directed bench for nes_pad_emulator: reset, debounce, full frame, tail, timeout, re-latch.
module tb_nes_pad_emulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   fd_cnt = 0;
  int   to_cnt = 0;

  nes_pad_emulator_if pif();

  nes_pad_emulator #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(1000), .TAIL_BIT(1'b1)
  ) dut (
    .clk(clk), .reset(rst_n), .pad(pif)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (pif.frame_done) fd_cnt <= fd_cnt + 1;
    if (pif.timeout)    to_cnt <= to_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch(input int len);
    pif.latch_in = 1'b1;
    tick(len);
    pif.latch_in = 1'b0;
    tick(20);
  endtask

  task automatic pulse(input int gap);
    pif.pulse_in = 1'b1;
    tick(8);
    pif.pulse_in = 1'b0;
    tick(gap - 8);
  endtask

  logic [7:0] frame_bits;
  int         lat;
  bit         seen;

  initial begin
    pif.latch_in   = 1'b0;
    pif.pulse_in   = 1'b0;
    pif.buttons_in = 8'h00;

    // 1: reset with random inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pif.latch_in   = 1'($urandom);
      pif.pulse_in   = 1'($urandom);
      pif.buttons_in = 8'($urandom);
    end
    chk("rst_data_out", pif.data_out, 1);
    chk("rst_busy", pif.busy, 0);
    chk("rst_db", pif.buttons_db, 8'h00);
    chk("rst_frame_done", pif.frame_done, 0);
    chk("rst_timeout", pif.timeout, 0);
    pif.latch_in = 1'b0; pif.pulse_in = 1'b0; pif.buttons_in = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // 2: debounce; glitch of 10 cycles rejected, then accepted after 2 sync + 16 count
    pif.buttons_in = 8'h08;
    tick(10);
    pif.buttons_in = 8'h00;
    tick(30);
    chk("db_glitch", pif.buttons_db, 8'h00);
    pif.buttons_in = 8'h08;
    tick(17);
    chk("db_edge_minus1", pif.buttons_db, 8'h00);
    tick(1);
    chk("db_edge", pif.buttons_db, 8'h08);
    chk("idle_busy", pif.busy, 0);

    // 3: full frame with A+Right
    pif.buttons_in = 8'h81;
    tick(30);
    chk("db_81", pif.buttons_db, 8'h81);
    latch(12);
    chk("frame_busy", pif.busy, 1);
    frame_bits = 8'b0111_1110;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("frame_bit%0d", i), pif.data_out, frame_bits[i]);
      pulse(600);
    end
    chk("frame_tail_data", pif.data_out, 1);
    chk("frame_done_cnt", fd_cnt, 1);

    // 4: extra pulses in TAIL are ignored
    for (int i = 0; i < 3; i++) pulse(100);
    chk("tail_data", pif.data_out, 1);
    chk("tail_fd_cnt", fd_cnt, 1);
    chk("tail_busy", pif.busy, 1);
    chk("tail_no_timeout", to_cnt, 0);

    // 5: timeout; strobe lands 2 sync + 1 edge-detect + 1000 timer cycles after pin rise
    latch(12);
    pulse(100);
    pulse(100);
    pif.pulse_in = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 1100 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 8) pif.pulse_in = 1'b0;
      if (pif.timeout) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk("to_latency", lat, 1003);
    tick(3);
    chk("to_busy", pif.busy, 0);
    chk("to_data", pif.data_out, 1);
    chk("to_cnt", to_cnt, 1);
    chk("to_no_fd", fd_cnt, 1);

    // 6: re-latch after pulse 4, coincident with a pulse
    latch(12);
    for (int i = 0; i < 4; i++) pulse(100);
    chk("pre_relatch_bit4", pif.data_out, 1);
    pif.latch_in = 1'b1;
    pif.pulse_in = 1'b1;
    tick(8);
    pif.pulse_in = 1'b0;
    tick(4);
    chk("relatch_notA", pif.data_out, 0);
    chk("relatch_busy", pif.busy, 1);
    pif.latch_in = 1'b0;
    tick(20);
    chk("relatch_fd", fd_cnt, 1);
    chk("relatch_bit0", pif.data_out, 0);
    pulse(100);
    chk("relatch_bit1", pif.data_out, 1);
    for (int i = 0; i < 7; i++) pulse(100);
    chk("relatch_tail", pif.data_out, 1);
    chk("relatch_fd_after", fd_cnt, 2);
    chk("relatch_no_to", to_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
